// File: rtl/tsc_defs.sv
// Shared definitions for the TSC multi-cycle control path: widths, opcode and
// func constants, sequencer states, instruction classes and select encodings.
package tsc_defs;

   localparam int TSC_WORD_SIZE  = 16;
   localparam int TSC_ADDR_BITNO = 2;
   localparam int LINK_REG       = 2;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_ALU_LAST = 6'd7;
   localparam logic [5:0] FN_JPR      = 6'd25;
   localparam logic [5:0] FN_JRL      = 6'd26;
   localparam logic [5:0] FN_WWD      = 6'd28;
   localparam logic [5:0] FN_HLT      = 6'd29;

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_REG    = 2'd3;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC  = 2'd2;

   typedef enum logic [3:0] {
      CLS_NOP,
      CLS_BRANCH,
      CLS_JMP,
      CLS_JPR,
      CLS_WWD,
      CLS_HLT,
      CLS_LWD,
      CLS_SWD,
      CLS_ALU,
      CLS_JAL,
      CLS_JRL
   } inst_class_e;

   // Classes that finish with a register-file write in WB.
   function automatic logic writes_back(inst_class_e c);
      return c inside {CLS_ALU, CLS_LWD, CLS_JAL, CLS_JRL};
   endfunction

endpackage

// File: rtl/tsc_decoder.sv
// Combinational instruction decoder: maps the instruction register onto an
// execution class, the write-back destination register and the write-back source.
module tsc_decoder
   import tsc_defs::*;
#(
   parameter int WORD_SIZE  = TSC_WORD_SIZE,
   parameter int ADDR_BITNO = TSC_ADDR_BITNO
) (
   input  logic [WORD_SIZE-1:0]  i_ir,
   output logic [3:0]            o_class,
   output logic [ADDR_BITNO-1:0] o_dest,
   output logic [1:0]            o_wb_sel
);

   logic [3:0]            w_op;
   logic [5:0]            w_func;
   logic [ADDR_BITNO-1:0] w_rt;
   logic [ADDR_BITNO-1:0] w_rd;
   logic                  w_unused_rs;
   inst_class_e           w_cls;

   assign w_op        = i_ir[15:12];
   assign w_func      = i_ir[5:0];
   assign w_rt        = ADDR_BITNO'(i_ir[9:8]);
   assign w_rd        = ADDR_BITNO'(i_ir[7:6]);
   // rs only feeds the register-file read port, never the sequencer.
   assign w_unused_rs = ^i_ir[11:10];

   always_comb begin
      w_cls    = CLS_NOP;
      o_dest   = '0;
      o_wb_sel = WB_SEL_ALU;
      case (w_op)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: w_cls = CLS_BRANCH;
         OP_ADI, OP_ORI, OP_LHI: begin
            w_cls  = CLS_ALU;
            o_dest = w_rt;
         end
         OP_LWD: begin
            w_cls    = CLS_LWD;
            o_dest   = w_rt;
            o_wb_sel = WB_SEL_MEM;
         end
         OP_SWD: w_cls = CLS_SWD;
         OP_JMP: w_cls = CLS_JMP;
         OP_JAL: begin
            w_cls    = CLS_JAL;
            o_dest   = ADDR_BITNO'(LINK_REG);
            o_wb_sel = WB_SEL_PC;
         end
         OP_RTYPE: begin
            if (w_func <= FN_ALU_LAST) begin
               w_cls  = CLS_ALU;
               o_dest = w_rd;
            end else begin
               case (w_func)
                  FN_JPR: w_cls = CLS_JPR;
                  FN_JRL: begin
                     w_cls    = CLS_JRL;
                     o_dest   = ADDR_BITNO'(LINK_REG);
                     o_wb_sel = WB_SEL_PC;
                  end
                  FN_WWD: w_cls = CLS_WWD;
                  FN_HLT: w_cls = CLS_HLT;
                  default: w_cls = CLS_NOP;
               endcase
            end
         end
         default: w_cls = CLS_NOP;
      endcase
   end

   assign o_class = w_cls;

endmodule

// File: rtl/tsc_mc_control.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the TSC CPU: owns the instruction
// register, the memory handshake, every register-file write and the retire count.
module tsc_mc_control
   import tsc_defs::*;
#(
   parameter int WORD_SIZE  = TSC_WORD_SIZE,
   parameter int ADDR_BITNO = TSC_ADDR_BITNO
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WORD_SIZE-1:0]  mem_data,
   input  logic                  inputReady,
   input  logic                  ackOutput,
   input  logic                  bcond,
   output logic [WORD_SIZE-1:0]  ir,
   output logic                  readM,
   output logic                  writeM,
   output logic                  i_or_d,
   output logic                  pc_write,
   output logic [1:0]            pc_src,
   output logic                  rf_write,
   output logic [ADDR_BITNO-1:0] rf_addr3,
   output logic [1:0]            wb_sel,
   output logic                  wwd_valid,
   output logic                  halted,
   output logic [WORD_SIZE-1:0]  num_inst
);

   logic [2:0]            r_state;
   logic [WORD_SIZE-1:0]  r_ir;
   logic [WORD_SIZE-1:0]  r_num_inst;

   logic [2:0]            w_next;
   logic [3:0]            w_class_raw;
   inst_class_e           w_class;
   logic [ADDR_BITNO-1:0] w_dest;
   logic [1:0]            w_dec_wb_sel;

   logic                  w_read;
   logic                  w_write;
   logic                  w_iord;
   logic                  w_pcw;
   logic [1:0]            w_pcsrc;
   logic                  w_rfw;
   logic [ADDR_BITNO-1:0] w_addr3;
   logic [1:0]            w_wbsel;
   logic                  w_wwd;
   logic                  w_halted;

   tsc_decoder #(
      .WORD_SIZE  (WORD_SIZE),
      .ADDR_BITNO (ADDR_BITNO)
   ) u_decoder (
      .i_ir     (r_ir),
      .o_class  (w_class_raw),
      .o_dest   (w_dest),
      .o_wb_sel (w_dec_wb_sel)
   );

   assign w_class = inst_class_e'(w_class_raw);

   // Outputs are Moore-decoded from state and ir; bcond and the handshake
   // pulses are the only inputs that reach them combinationally.
   always_comb begin
      w_next   = r_state;
      w_read   = 1'b0;
      w_write  = 1'b0;
      w_iord   = 1'b0;
      w_pcw    = 1'b0;
      w_pcsrc  = PC_SRC_NEXT;
      w_rfw    = 1'b0;
      w_addr3  = '0;
      w_wbsel  = WB_SEL_ALU;
      w_wwd    = 1'b0;
      w_halted = 1'b0;
      case (r_state)
         S_IF: begin
            w_read = 1'b1;
            if (inputReady) w_next = S_ID;
         end
         S_ID: w_next = S_EX;
         S_EX: begin
            w_next = S_IF;
            case (w_class)
               CLS_BRANCH: begin
                  w_pcw   = 1'b1;
                  w_pcsrc = bcond ? PC_SRC_BRANCH : PC_SRC_NEXT;
               end
               CLS_JMP: begin
                  w_pcw   = 1'b1;
                  w_pcsrc = PC_SRC_JUMP;
               end
               CLS_JPR: begin
                  w_pcw   = 1'b1;
                  w_pcsrc = PC_SRC_REG;
               end
               CLS_WWD: begin
                  w_pcw = 1'b1;
                  w_wwd = 1'b1;
               end
               CLS_HLT: w_next = S_HALT;
               CLS_LWD, CLS_SWD: w_next = S_MEM;
               default: begin
                  if (writes_back(w_class)) w_next = S_WB;
                  else w_pcw = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            w_iord = 1'b1;
            if (w_class == CLS_LWD) begin
               w_read = 1'b1;
               if (inputReady) w_next = S_WB;
            end else begin
               w_write = 1'b1;
               if (ackOutput) begin
                  w_pcw  = 1'b1;
                  w_next = S_IF;
               end
            end
         end
         S_WB: begin
            w_rfw   = 1'b1;
            w_addr3 = w_dest;
            w_wbsel = w_dec_wb_sel;
            w_pcw   = 1'b1;
            if (w_class == CLS_JAL)      w_pcsrc = PC_SRC_JUMP;
            else if (w_class == CLS_JRL) w_pcsrc = PC_SRC_REG;
            else                         w_pcsrc = PC_SRC_NEXT;
            w_next  = S_IF;
         end
         S_HALT: w_halted = 1'b1;
         default: w_next = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IF;
         r_ir       <= '0;
         r_num_inst <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IF && inputReady) r_ir <= mem_data;
         if (w_pcw) r_num_inst <= r_num_inst + WORD_SIZE'(1);
      end
   end

   // Reset must silence every output in the same cycle, even before the
   // first clock edge has cleared the state.
   assign ir        = reset_n ? r_ir : '0;
   assign readM     = reset_n & w_read;
   assign writeM    = reset_n & w_write;
   assign i_or_d    = reset_n & w_iord;
   assign pc_write  = reset_n & w_pcw;
   assign pc_src    = reset_n ? w_pcsrc : '0;
   assign rf_write  = reset_n & w_rfw;
   assign rf_addr3  = reset_n ? w_addr3 : '0;
   assign wb_sel    = reset_n ? w_wbsel : '0;
   assign wwd_valid = reset_n & w_wwd;
   assign halted    = reset_n & w_halted;
   assign num_inst  = reset_n ? r_num_inst : '0;

endmodule

// File: tb/tb_tsc_mc_control.sv
// Bench for tsc_mc_control: an instruction-level model builds the expected
// per-cycle output trace, with literal pins on the key cycle counts and fields.
module tb_tsc_mc_control;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_data;
   logic        inputReady;
   logic        ackOutput;
   logic        bcond;
   logic [15:0] ir;
   logic        readM;
   logic        writeM;
   logic        i_or_d;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        rf_write;
   logic [1:0]  rf_addr3;
   logic [1:0]  wb_sel;
   logic        wwd_valid;
   logic        halted;
   logic [15:0] num_inst;

   always #5 clk = ~clk;

   tsc_mc_control #(
      .WORD_SIZE  (16),
      .ADDR_BITNO (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_data   (mem_data),
      .inputReady (inputReady),
      .ackOutput  (ackOutput),
      .bcond      (bcond),
      .ir         (ir),
      .readM      (readM),
      .writeM     (writeM),
      .i_or_d     (i_or_d),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .rf_write   (rf_write),
      .rf_addr3   (rf_addr3),
      .wb_sel     (wb_sel),
      .wwd_valid  (wwd_valid),
      .halted     (halted),
      .num_inst   (num_inst)
   );

   typedef struct packed {
      logic        readM;
      logic        writeM;
      logic        i_or_d;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic        rf_write;
      logic [1:0]  rf_addr3;
      logic [1:0]  wb_sel;
      logic        wwd_valid;
      logic        halted;
      logic [15:0] ir;
      logic [15:0] num;
   } obs_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc_no = 0;
   int          inst_start = 0;
   int          rfw_total = 0;
   int          pcw_total = 0;
   int          last_rfw_cyc = 0;
   int          last_pcw_cyc = 0;
   logic [1:0]  last_a3 = 2'd0;
   logic [1:0]  last_ws = 2'd0;
   logic [1:0]  last_ps = 2'd0;
   logic [15:0] exp_ir = 16'h0;
   logic [15:0] exp_num = 16'h0;

   function automatic obs_t base();
      obs_t e;
      e     = '0;
      e.ir  = exp_ir;
      e.num = exp_num;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t g;
      g.readM     = readM;
      g.writeM    = writeM;
      g.i_or_d    = i_or_d;
      g.pc_write  = pc_write;
      g.pc_src    = pc_src;
      g.rf_write  = rf_write;
      g.rf_addr3  = rf_addr3;
      g.wb_sel    = wb_sel;
      g.wwd_valid = wwd_valid;
      g.halted    = halted;
      g.ir        = ir;
      g.num       = num_inst;
      return g;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("rdM=%b wrM=%b iod=%b pcw=%b psrc=%0d rfw=%b a3=%0d wbs=%0d wwd=%b hlt=%b ir=%h n=%0d",
                       o.readM, o.writeM, o.i_or_d, o.pc_write, o.pc_src, o.rf_write,
                       o.rf_addr3, o.wb_sel, o.wwd_valid, o.halted, o.ir, o.num);
   endfunction

   // One clock cycle: drive inputs after the edge, compare on the falling edge.
   task automatic cyc(input logic rn, input logic irdy, input logic ack, input logic [15:0] md,
                      input logic bc, input obs_t e, input string tag);
      obs_t g;
      @(posedge clk);
      #1;
      reset_n    = rn;
      inputReady = irdy;
      ackOutput  = ack;
      mem_data   = md;
      bcond      = bc;
      cyc_no++;
      @(negedge clk);
      g = sample();
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %s, required %s", tag, cyc_no, fmt(g), fmt(e));
      end
      if (rf_write === 1'b1) begin
         rfw_total++;
         last_rfw_cyc = cyc_no;
         last_a3      = rf_addr3;
         last_ws      = wb_sel;
      end
      if (pc_write === 1'b1) begin
         pcw_total++;
         last_pcw_cyc = cyc_no;
         last_ps      = pc_src;
      end
      if (e.pc_write) exp_num = exp_num + 16'd1;
   endtask

   task automatic lit(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, obs_t'('0), "reset");
      exp_ir  = 16'h0;
      exp_num = 16'h0;
   endtask

   task automatic idle_if(input int n);
      obs_t e;
      for (int k = 0; k < n; k++) begin
         e       = base();
         e.readM = 1'b1;
         cyc(1'b1, 1'b0, 1'b0, 16'hDEAD, 1'b0, e, "idle IF");
      end
   endtask

   task automatic halt_cycles(input int n, input logic noise);
      obs_t e;
      for (int k = 0; k < n; k++) begin
         e        = base();
         e.halted = 1'b1;
         cyc(1'b1, noise, noise, 16'hBEEF, 1'b0, e, "HALT");
      end
   endtask

   // Instruction-level model: derives the whole cycle trace from the ISA rules.
   // abort >= 0 stops the instruction after that many MEM wait cycles.
   task automatic run_inst(input string name, input logic [15:0] instr, input int fdly,
                           input int mdly, input logic bc, input logic noise, input int abort);
      logic [3:0] op;
      logic [5:0] fn;
      logic       is_rt, is_br, is_imm, is_alu, is_lwd, is_swd, is_jmp, is_jal;
      logic       is_jpr, is_jrl, is_wwd, is_hlt, is_nop;
      obs_t       e;
      op     = instr[15:12];
      fn     = instr[5:0];
      is_rt  = (op == 4'd15);
      is_br  = (op <= 4'd3);
      is_imm = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
      is_alu = is_imm || (is_rt && fn <= 6'd7);
      is_lwd = (op == 4'd7);
      is_swd = (op == 4'd8);
      is_jmp = (op == 4'd9);
      is_jal = (op == 4'd10);
      is_jpr = is_rt && fn == 6'd25;
      is_jrl = is_rt && fn == 6'd26;
      is_wwd = is_rt && fn == 6'd28;
      is_hlt = is_rt && fn == 6'd29;
      is_nop = !(is_br || is_alu || is_lwd || is_swd || is_jmp || is_jal ||
                 is_jpr || is_jrl || is_wwd || is_hlt);
      inst_start = cyc_no;
      for (int k = 0; k <= fdly; k++) begin
         e       = base();
         e.readM = 1'b1;
         cyc(1'b1, k == fdly, noise, (k == fdly) ? instr : 16'hDEAD, bc, e, {name, " IF"});
      end
      exp_ir = instr;
      cyc(1'b1, noise, noise, 16'hBEEF, bc, base(), {name, " ID"});
      e = base();
      if (is_br || is_jmp || is_jpr || is_wwd || is_nop) begin
         e.pc_write  = 1'b1;
         e.pc_src    = is_br ? (bc ? 2'd1 : 2'd0) : is_jmp ? 2'd2 : is_jpr ? 2'd3 : 2'd0;
         e.wwd_valid = is_wwd;
      end
      cyc(1'b1, noise, noise, 16'hBEEF, bc, e, {name, " EX"});
      if (is_lwd || is_swd) begin
         for (int k = 0; k <= mdly; k++) begin
            if (abort >= 0 && k == abort) return;
            e          = base();
            e.i_or_d   = 1'b1;
            e.readM    = is_lwd;
            e.writeM   = is_swd;
            e.pc_write = is_swd && k == mdly;
            if (is_lwd) cyc(1'b1, k == mdly, noise, (k == mdly) ? 16'h5A5A : 16'hDEAD, bc, e, {name, " MEM"});
            else        cyc(1'b1, noise, k == mdly, 16'hBEEF, bc, e, {name, " MEM"});
         end
      end
      if (is_alu || is_lwd || is_jal || is_jrl) begin
         e          = base();
         e.rf_write = 1'b1;
         e.rf_addr3 = (is_jal || is_jrl) ? 2'd2 : (is_rt && is_alu) ? instr[7:6] : instr[9:8];
         e.wb_sel   = is_lwd ? 2'd1 : (is_jal || is_jrl) ? 2'd2 : 2'd0;
         e.pc_write = 1'b1;
         e.pc_src   = is_jal ? 2'd2 : is_jrl ? 2'd3 : 2'd0;
         cyc(1'b1, noise, noise, 16'hBEEF, bc, e, {name, " WB"});
      end
   endtask

   int snap_p;
   int snap_r;

   initial begin
      reset_n    = 1'b0;
      inputReady = 1'b0;
      ackOutput  = 1'b0;
      bcond      = 1'b0;
      mem_data   = 16'h0;

      do_reset(3);
      snap_p = pcw_total;
      idle_if(5);
      lit("idle pc_write count", pcw_total - snap_p, 0);
      lit("idle num_inst", int'(num_inst), 0);

      run_inst("ADD", 16'hF6C0, 0, 0, 1'b0, 1'b0, -1);
      lit("ADD rf_write cycle", last_rfw_cyc - inst_start, 4);
      lit("ADD rf_addr3", int'(last_a3), 3);
      lit("ADD wb_sel", int'(last_ws), 0);
      idle_if(1);
      lit("ADD num_inst", int'(num_inst), 1);

      run_inst("LWD", 16'h7104, 0, 2, 1'b0, 1'b0, -1);
      lit("LWD rf_write cycle", last_rfw_cyc - inst_start, 7);
      lit("LWD rf_addr3", int'(last_a3), 1);
      lit("LWD wb_sel", int'(last_ws), 1);

      snap_r = rfw_total;
      run_inst("BEQ taken", 16'h1002, 0, 0, 1'b1, 1'b1, -1);
      lit("BEQ taken pc_write cycle", last_pcw_cyc - inst_start, 3);
      lit("BEQ taken pc_src", int'(last_ps), 1);
      run_inst("BEQ not taken", 16'h1002, 0, 0, 1'b0, 1'b0, -1);
      lit("BEQ not taken pc_write cycle", last_pcw_cyc - inst_start, 3);
      lit("BEQ not taken pc_src", int'(last_ps), 0);
      lit("BEQ rf_write count", rfw_total - snap_r, 0);

      run_inst("ORI", 16'h5200, 0, 0, 1'b0, 1'b1, -1);
      lit("ORI rf_addr3", int'(last_a3), 2);
      run_inst("SWD late ack", 16'h8100, 0, 1, 1'b0, 1'b1, -1);
      lit("SWD late ack pc_write cycle", last_pcw_cyc - inst_start, 5);
      run_inst("JMP late fetch", 16'h9005, 2, 0, 1'b0, 1'b0, -1);
      lit("JMP pc_write cycle", last_pcw_cyc - inst_start, 5);
      lit("JMP pc_src", int'(last_ps), 2);
      run_inst("JPR", 16'hF019, 0, 0, 1'b0, 1'b1, -1);
      lit("JPR pc_src", int'(last_ps), 3);
      run_inst("JRL", 16'hF01A, 0, 0, 1'b0, 1'b0, -1);
      lit("JRL rf_write cycle", last_rfw_cyc - inst_start, 4);
      lit("JRL rf_addr3", int'(last_a3), 2);
      lit("JRL pc_src", int'(last_ps), 3);
      run_inst("WWD", 16'hF01C, 0, 0, 1'b0, 1'b1, -1);
      run_inst("NOP opcode", 16'hB000, 0, 0, 1'b0, 1'b0, -1);
      lit("NOP pc_write cycle", last_pcw_cyc - inst_start, 3);
      run_inst("NOP func", 16'hF008, 0, 0, 1'b0, 1'b1, -1);
      run_inst("LHI", 16'h6300, 0, 0, 1'b0, 1'b0, -1);
      lit("LHI rf_addr3", int'(last_a3), 3);
      run_inst("SWD", 16'h8000, 0, 0, 1'b0, 1'b0, -1);
      lit("SWD pc_write cycle", last_pcw_cyc - inst_start, 4);
      run_inst("BLZ late fetch", 16'h3000, 1, 0, 1'b1, 1'b1, -1);
      lit("BLZ pc_write cycle", last_pcw_cyc - inst_start, 4);
      run_inst("JAL", 16'hA010, 0, 0, 1'b0, 1'b0, -1);
      lit("JAL rf_addr3", int'(last_a3), 2);
      lit("JAL wb_sel", int'(last_ws), 2);
      lit("JAL pc_src", int'(last_ps), 2);

      snap_p = pcw_total;
      run_inst("HLT", 16'hF01D, 0, 0, 1'b0, 1'b0, -1);
      halt_cycles(5, 1'b1);
      lit("HLT num_inst", int'(num_inst), 16);
      lit("HLT halted", int'(halted), 1);
      lit("HLT readM", int'(readM), 0);
      lit("HLT pc_write count", pcw_total - snap_p, 0);

      do_reset(2);
      run_inst("SWD aborted", 16'h8200, 0, 5, 1'b0, 1'b0, 2);
      snap_p = pcw_total;
      snap_r = rfw_total;
      do_reset(2);
      idle_if(3);
      lit("abort num_inst", int'(num_inst), 0);
      lit("abort writeM", int'(writeM), 0);
      lit("abort readM", int'(readM), 1);
      lit("abort ir", int'(ir), 0);
      lit("abort pc_write count", pcw_total - snap_p, 0);
      lit("abort rf_write count", rfw_total - snap_r, 0);

      run_inst("ADD after reset", 16'hF6C0, 0, 0, 1'b0, 1'b0, -1);
      idle_if(1);
      lit("restart num_inst", int'(num_inst), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tsc_mc_control.md
# tsc_mc_control

Multi-cycle instruction sequencer for the 16-bit TSC CPU. It fetches each instruction through the memory handshake, holds the instruction register, and walks the IF/ID/EX/MEM/WB state machine. It drives the register file's write port (`rf_write`, `rf_addr3`) and the datapath select and enable lines. It sits directly upstream of the register file and owns every write the register file receives.

## Interface
- `WORD_SIZE`, default 16: instruction/data width.
- `ADDR_BITNO`, default 2: register-address width (4 registers).
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `mem_data`  in  WORD_SIZE: memory read data, valid when `inputReady`=1.
- `inputReady`  in  1: single-cycle pulse, read data valid.
- `ackOutput`  in  1: single-cycle pulse, write accepted.
- `bcond`  in  1: ALU branch-condition result, valid in EX.
- `ir`  out  WORD_SIZE: instruction register.
- `readM` / `writeM`  out  1: memory read/write request.
- `i_or_d`  out  1: memory address select, 0=PC, 1=ALU result.
- `pc_write`  out  1: PC update strobe.
- `pc_src`  out  2: 0=PC+1, 1=branch target, 2=jump target, 3=rs register.
- `rf_write`  out  1: register-file write enable.
- `rf_addr3`  out  ADDR_BITNO: register-file write address.
- `wb_sel`  out  2: write-back data, 0=ALU, 1=memory, 2=PC+1.
- `wwd_valid`  out  1: output-port strobe for WWD.
- `halted`  out  1: HLT executed.
- `num_inst`  out  WORD_SIZE: count of retired instructions.

## Operation
- IR fields: opcode [15:12], rs [11:10], rt [9:8], rd [7:6], func [5:0].
- Opcodes: 0–3 are BNE/BEQ/BGZ/BLZ; 4 ADI; 5 ORI; 6 LHI; 7 LWD; 8 SWD; 9 JMP; 10 JAL; 15 is R-type.
- R-type func codes: 0–7 are ALU ops; 25 JPR; 26 JRL; 28 WWD; 29 HLT.
- Every other opcode or func code is a NOP: the instruction retires with PC+1.
- IF: `readM`=1, `i_or_d`=0. On `inputReady`, latch `mem_data` into `ir` and go to ID.
- ID: one cycle so register-file reads settle. Always goes to EX.
- EX, by instruction class:
  - Branch: `pc_write`=1, `pc_src`=`bcond`?1:0, then IF.
  - JMP: `pc_src`=2, then IF.
  - JPR: `pc_src`=3, then IF.
  - WWD: `wwd_valid`=1, `pc_src`=0, then IF.
  - HLT: go to HALT.
  - LWD/SWD: go to MEM.
  - ALU ops, JAL, JRL: go to WB.
- MEM, LWD: `readM`=1, `i_or_d`=1. Wait for `inputReady`, then WB.
- MEM, SWD: `writeM`=1, `i_or_d`=1. Wait for `ackOutput`, then `pc_write` with `pc_src`=0 and go to IF.
- WB: `rf_write`=1 for one cycle.
  - Destination: rd for R-type ALU ops; rt for ADI/ORI/LHI/LWD; 2 for JAL/JRL.
  - `wb_sel`: 0 for ALU ops, 1 for LWD, 2 for JAL/JRL.
  - PC: `pc_write`=1 with `pc_src`=0, except JAL uses 2 and JRL uses 3. Then IF.
- HALT: `halted`=1. Absorbing until reset; no memory requests.
- `num_inst`: increments by 1 in each cycle that asserts `pc_write`. Wraps modulo 2^WORD_SIZE. Not incremented for HLT.
- All control outputs are Moore-decoded from state plus `ir`. The only exceptions are `bcond` feeding `pc_src`, and the handshake inputs gating the exit from a wait state.

## Timing
- Reset (sampled at `clk`): state=IF; `ir`=0; `num_inst`=0; `halted`=0.
  - While `reset_n`=0, all outputs are forced to 0, including `readM`.
  - `readM` rises in the first cycle after release.
- Cycle counts, with the handshake arriving in the first wait cycle:
  - Branch/jump/WWD: 3 cycles.
  - ALU/JAL/JRL: 4 cycles.
  - SWD: 4 cycles.
  - LWD: 5 cycles.
- Each added cycle of handshake delay adds exactly one cycle.
- `inputReady`/`ackOutput` are ignored outside their wait state. A pulse arriving in the same cycle as the request completes it.
- Reset mid-instruction, in any state: abort with no `rf_write` and no `pc_write`. `num_inst` returns to 0.
- `rf_write` and `pc_write` are never asserted for more than one cycle per instruction.

## Structure
- Shared package `tsc_defs`: `WORD_SIZE`, opcode and func constants, state enum, and the `pc_src`/`wb_sel` encodings.
- Sub-module `tsc_decoder` (combinational):
  - Input: `ir`.
  - Outputs: instruction class, destination register, `wb_sel`.
- The sequencer FSM and counters live in `tsc_mc_control`.

## Test plan
- Reset, then hold `inputReady` low for 5 cycles → `readM`=1 throughout, `num_inst`=0, no `pc_write`.
- Fetch ADD $1,$2,$3 (0xF6C0) with immediate `inputReady` → `rf_write` in cycle 4 with `rf_addr3`=3, `wb_sel`=0; `num_inst`=1.
- LWD $1 (0x7104), memory ready 2 cycles late → WB in cycle 7 with `rf_addr3`=1, `wb_sel`=1.
- BEQ (0x1002) with `bcond`=1, then again with `bcond`=0 → `pc_src`=1, then 0; 3 cycles each; `rf_write` never asserted.
- JAL (0xA010) → `rf_addr3`=2, `wb_sel`=2, `pc_src`=2. Then HLT (0xF01D) → `halted`=1, `readM` stays 0, `num_inst` frozen.
- Assert `reset_n`=0 during SWD MEM wait → no `writeM` after reset, `num_inst`=0, IF restarts.
